// File: rtl/bit32loader_if.sv
// Front-panel bundle for bit32loader: switch byte, lane select and buttons
// go in; the count, LED byte and done flag come out.
interface bit32loader_if;
    logic [7:0]  sw;
    logic [1:0]  sel;
    logic        wr;
    logic        go;
    logic [31:0] q;
    logic [7:0]  led;
    logic        done;

    modport master (
        output sw, sel, wr, go,
        input  q, led, done
    );

    modport slave (
        input  sw, sel, wr, go,
        output q, led, done
    );
endinterface

// File: rtl/bit32loader.sv
// Byte-wise 32-bit staging loader and prescaled down-counter for the
// 8-switch/8-LED panel; done flags terminal count.
module bit32loader #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic         clk,
    input  logic         rst,
    bit32loader_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam logic [31:0] PC_LAST = 32'(TICK_DIV - 1);

    state_t      state_q, state_d;
    logic [31:0] stage_q, stage_d;
    logic [31:0] q_q, q_d;
    logic [31:0] pc_q, pc_d;
    logic        done_q, done_d;

    logic        wr_s1_q, wr_s2_q, wr_prev_q;
    logic        go_s1_q, go_s2_q, go_prev_q;
    logic        wr_pulse, go_pulse, tick;
    logic [31:0] view;
    logic [7:0]  led_o;

    function automatic logic [31:0] put_byte(input logic [31:0] word,
                                             input logic [1:0]  lane,
                                             input logic [7:0]  data);
        logic [31:0] r;
        r = word;
        r[{lane, 3'b000} +: 8] = data;
        return r;
    endfunction

    // Buttons are asynchronous levels: synchronize, then edge-detect so a
    // held button yields a single pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_s1_q   <= 1'b0;
            wr_s2_q   <= 1'b0;
            wr_prev_q <= 1'b0;
            go_s1_q   <= 1'b0;
            go_s2_q   <= 1'b0;
            go_prev_q <= 1'b0;
        end else begin
            wr_s1_q   <= bus.wr;
            wr_s2_q   <= wr_s1_q;
            wr_prev_q <= wr_s2_q;
            go_s1_q   <= bus.go;
            go_s2_q   <= go_s1_q;
            go_prev_q <= go_s2_q;
        end
    end

    assign wr_pulse = wr_s2_q & ~wr_prev_q;
    assign go_pulse = go_s2_q & ~go_prev_q;
    assign tick     = (pc_q == PC_LAST);

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        q_d     = q_q;
        pc_d    = pc_q;
        unique case (state_q)
            ST_IDLE: begin
                if (wr_pulse) begin
                    stage_d = put_byte(stage_q, bus.sel, bus.sw);
                end
                if (go_pulse) begin
                    q_d     = stage_q;
                    pc_d    = 32'd0;
                    state_d = (stage_q != 32'd0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                // An abort outranks a coincident tick, so q is left untouched.
                if (go_pulse) begin
                    pc_d    = 32'd0;
                    state_d = ST_IDLE;
                end else if (tick) begin
                    pc_d = 32'd0;
                    q_d  = q_q - 32'd1;
                    if (q_q == 32'd1) begin
                        state_d = ST_DONE;
                    end
                end else begin
                    pc_d = pc_q + 32'd1;
                end
            end
            ST_DONE: begin
                if (go_pulse) begin
                    q_d     = stage_q;
                    pc_d    = 32'd0;
                    state_d = (stage_q != 32'd0) ? ST_RUN : ST_DONE;
                end else if (wr_pulse) begin
                    stage_d = put_byte(stage_q, bus.sel, bus.sw);
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            stage_q <= 32'd0;
            q_q     <= 32'd0;
            pc_q    <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            q_q     <= q_d;
            pc_q    <= pc_d;
            done_q  <= done_d;
        end
    end

    // The LEDs show what the operator is editing in IDLE, otherwise the count.
    always_comb begin
        view  = (state_q == ST_IDLE) ? stage_q : q_q;
        led_o = view[{bus.sel, 3'b000} +: 8];
    end

    assign bus.q    = q_q;
    assign bus.led  = led_o;
    assign bus.done = done_q;
endmodule

// File: tb/tb_bit32loader.sv
// Scoreboard bench for bit32loader: two instances (TICK_DIV 1 and 4) share
// stimulus; an arithmetic countdown model predicts q/done changes and LED bytes.
module tb_bit32loader;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  sw_r;
    logic [1:0]  sel_r;
    logic        wr_r;
    logic        go_r;
    int unsigned cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bit32loader_if b1();
    bit32loader_if b4();

    assign b1.sw  = sw_r;
    assign b1.sel = sel_r;
    assign b1.wr  = wr_r;
    assign b1.go  = go_r;
    assign b4.sw  = sw_r;
    assign b4.sel = sel_r;
    assign b4.wr  = wr_r;
    assign b4.go  = go_r;

    bit32loader #(.TICK_DIV(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    bit32loader #(.TICK_DIV(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));

    logic [31:0] dq[2];
    logic [7:0]  dled[2];
    logic        ddone[2];
    assign dq[0] = b1.q;    assign dq[1] = b4.q;
    assign dled[0] = b1.led; assign dled[1] = b4.led;
    assign ddone[0] = b1.done; assign ddone[1] = b4.done;

    typedef struct {
        int unsigned cyc;
        logic [31:0] q;
        logic        done;
    } evt_t;

    typedef struct {
        int unsigned cyc;
        logic [1:0]  sel;
        logic [7:0]  led0;
        logic [7:0]  led1;
    } probe_t;

    evt_t   evq[2][$];
    probe_t prq[$];
    evt_t   me;
    probe_t mp;
    logic [32:0] last[2];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: per instance, either idle holding a count, or a
    // countdown that started from n_m at load_m (done once it reaches zero).
    logic        mode_m[2];
    int unsigned load_m[2];
    logic [31:0] n_m[2];
    logic [31:0] hold_m[2];
    logic [7:0]  stage_m[2][4];

    function automatic int unsigned td_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    function automatic logic [31:0] stage_word(input int d);
        return {stage_m[d][3], stage_m[d][2], stage_m[d][1], stage_m[d][0]};
    endfunction

    function automatic logic [31:0] val_at(input int d, input int unsigned e);
        int unsigned k;
        if (!mode_m[d]) return hold_m[d];
        k = (e - load_m[d]) / td_of(d);
        if (k >= n_m[d]) return 32'd0;
        return n_m[d] - k;
    endfunction

    function automatic logic done_at(input int d, input int unsigned e);
        return mode_m[d] && (val_at(d, e) == 32'd0);
    endfunction

    function automatic logic [7:0] led_exp(input int d, input int unsigned e, input logic [1:0] s);
        logic [31:0] v;
        v = mode_m[d] ? val_at(d, e) : stage_word(d);
        return v[{s, 3'b000} +: 8];
    endfunction

    task automatic trim(input int d, input int unsigned c);
        while (evq[d].size() > 0 && evq[d][evq[d].size() - 1].cyc >= c)
            void'(evq[d].pop_back());
    endtask

    task automatic model_write(input int d, input int unsigned w, input logic [1:0] lane, input logic [7:0] data);
        if (!mode_m[d]) begin
            stage_m[d][lane] = data;
        end else if (done_at(d, w - 1)) begin
            evq[d].push_back('{w, 32'd0, 1'b0});
            mode_m[d] = 1'b0;
            hold_m[d] = 32'd0;
            stage_m[d][lane] = data;
        end
    endtask

    task automatic model_go(input int d, input int unsigned a);
        logic [31:0] pv, n, v;
        logic        pd;
        if (mode_m[d] && !done_at(d, a - 1)) begin
            trim(d, a);
            hold_m[d] = val_at(d, a - 1);
            mode_m[d] = 1'b0;
        end else begin
            pv = mode_m[d] ? 32'd0 : hold_m[d];
            pd = mode_m[d];
            n  = stage_word(d);
            mode_m[d] = 1'b1;
            load_m[d] = a;
            n_m[d]    = n;
            for (int unsigned j = 0; j <= n; j++) begin
                v = n - j;
                if (!(j == 0 && v == pv && (v == 32'd0) == pd))
                    evq[d].push_back('{a + j * td_of(d), v, (v == 32'd0)});
            end
        end
    endtask

    task automatic model_reset(input int unsigned e);
        for (int d = 0; d < 2; d++) begin
            trim(d, e);
            if (val_at(d, e - 1) != 32'd0 || done_at(d, e - 1))
                evq[d].push_back('{e, 32'd0, 1'b0});
            mode_m[d] = 1'b0;
            hold_m[d] = 32'd0;
            for (int b = 0; b < 4; b++) stage_m[d][b] = 8'h00;
        end
    endtask

    // Monitor: every visible q/done change must be the next predicted event.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (evq[d].size() > 0 && evq[d][0].cyc < cyc) begin
                n_checks++;
                n_fail++;
                me = evq[d].pop_front();
                $display("[TB] FAIL missed_event dut%0d: no change by cycle %0d, required q=%h done=%b at cycle %0d",
                         d, cyc, me.q, me.done, me.cyc);
            end
            if ({dq[d], ddone[d]} != last[d]) begin
                n_checks++;
                if (evq[d].size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL unexpected_change dut%0d cycle %0d: got q=%h done=%b, required no change",
                             d, cyc, dq[d], ddone[d]);
                end else begin
                    me = evq[d].pop_front();
                    if (me.cyc != cyc || me.q != dq[d] || me.done != ddone[d]) begin
                        n_fail++;
                        $display("[TB] FAIL event dut%0d: got cycle %0d q=%h done=%b, required cycle %0d q=%h done=%b",
                                 d, cyc, dq[d], ddone[d], me.cyc, me.q, me.done);
                    end
                end
                last[d] = {dq[d], ddone[d]};
            end
        end
        while (prq.size() > 0 && prq[0].cyc <= cyc) begin
            mp = prq.pop_front();
            n_checks += 2;
            if (dled[0] !== mp.led0) begin
                n_fail++;
                $display("[TB] FAIL led dut0 cycle %0d sel=%0d: got %h required %h", cyc, mp.sel, dled[0], mp.led0);
            end
            if (dled[1] !== mp.led1) begin
                n_fail++;
                $display("[TB] FAIL led dut1 cycle %0d sel=%0d: got %h required %h", cyc, mp.sel, dled[1], mp.led1);
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_wr(input logic [1:0] lane, input logic [7:0] data);
        sw_r  = data;
        sel_r = lane;
        wr_r  = 1'b1;
        tick(3);
        for (int d = 0; d < 2; d++) model_write(d, cyc, lane, data);
        wr_r = 1'b0;
        tick(1);
    endtask

    task automatic press_go(output int unsigned a);
        go_r = 1'b1;
        tick(3);
        a = cyc;
        for (int d = 0; d < 2; d++) model_go(d, a);
        go_r = 1'b0;
        tick(1);
    endtask

    task automatic probe(input logic [1:0] s);
        sel_r = s;
        prq.push_back('{cyc, s, led_exp(0, cyc, s), led_exp(1, cyc, s)});
        tick(1);
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_q1"}, dq[0], 32'd0);
        check_output({tag, "_q4"}, dq[1], 32'd0);
        check_output({tag, "_done1"}, {31'd0, ddone[0]}, 32'd0);
        check_output({tag, "_done4"}, {31'd0, ddone[1]}, 32'd0);
        check_output({tag, "_led1"}, {24'd0, dled[0]}, 32'd0);
        check_output({tag, "_led4"}, {24'd0, dled[1]}, 32'd0);
    endtask

    task automatic apply_stimulus();
        int unsigned a;
        int          op;
        logic [1:0]  lane;

        // Reset with both buttons held; only wr stays held across release.
        rst = 1'b1; wr_r = 1'b1; go_r = 1'b1; sw_r = 8'hA5; sel_r = 2'd2;
        tick(3);
        check_all_zero("in_reset");
        go_r = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(3);
        for (int d = 0; d < 2; d++) model_write(d, cyc, 2'd2, 8'hA5);
        sw_r = 8'h3C;
        tick(5);
        probe(2'd2);
        probe(2'd0);
        wr_r = 1'b0;
        tick(2);

        // Build 0x12345678 and sweep the LED view across all lanes.
        press_wr(2'd0, 8'h78);
        press_wr(2'd1, 8'h56);
        press_wr(2'd2, 8'h34);
        press_wr(2'd3, 8'h12);
        for (int s = 0; s < 4; s++) probe(2'(s));

        // Countdown from 3.
        press_wr(2'd1, 8'h00);
        press_wr(2'd2, 8'h00);
        press_wr(2'd3, 8'h00);
        press_wr(2'd0, 8'h03);
        press_go(a);
        for (int i = 0; i < 4; i++) probe(2'd0);
        tick(20);

        // Countdown from 5, abort timed onto the fourth-cycle tick of dut4.
        press_wr(2'd0, 8'h05);
        press_go(a);
        tick(int'(a + 9 - cyc));
        press_go(a);
        probe(2'd0);
        tick(10);
        press_go(a);
        tick(30);

        // Zero stage goes straight to DONE; a write there returns to IDLE.
        press_wr(2'd0, 8'h00);
        press_go(a);
        probe(2'd0);
        press_wr(2'd1, 8'h22);
        probe(2'd1);

        // Writes while running are ignored.
        press_wr(2'd1, 8'h00);
        press_wr(2'd0, 8'h10);
        press_go(a);
        press_wr(2'd0, 8'hEE);
        probe(2'd0);
        tick(70);
        probe(2'd0);
        press_go(a);
        tick(5);
        press_go(a);
        probe(2'd0);

        // Asynchronous reset in the middle of a 0x100 countdown.
        press_wr(2'd1, 8'h01);
        press_wr(2'd0, 8'h00);
        press_go(a);
        check_output("pre_reset_q4", dq[1], 32'h100);
        @(negedge clk);
        #1;
        rst = 1'b1;
        model_reset(cyc + 1);
        #1;
        check_all_zero("async_reset");
        tick(2);
        rst = 1'b0;
        tick(2);

        // Randomized mix of writes, starts/aborts, waits and LED probes.
        for (int i = 0; i < 40; i++) begin
            op = int'($urandom_range(0, 3));
            if (op <= 1) begin
                lane = 2'($urandom_range(0, 3));
                press_wr(lane, (lane == 2'd0) ? 8'($urandom_range(0, 24)) : 8'h00);
            end else if (op == 2) begin
                press_go(a);
            end else begin
                tick(int'($urandom_range(0, 8)));
            end
            probe(2'($urandom_range(0, 3)));
        end
        tick(120);
    endtask

    initial begin
        last[0] = 33'd0;
        last[1] = 33'd0;
        for (int d = 0; d < 2; d++) begin
            mode_m[d] = 1'b0;
            hold_m[d] = 32'd0;
            load_m[d] = 0;
            n_m[d]    = 32'd0;
            for (int b = 0; b < 4; b++) stage_m[d][b] = 8'h00;
        end
        apply_stimulus();
        check_output("pending_events_dut1", evq[0].size(), 32'd0);
        check_output("pending_events_dut4", evq[1].size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
